// File: rtl/alu_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_decode                                                           |
// | RV32I OP/OP-IMM/LUI/AUIPC decode into a registered ALU-entry stage.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_decode #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      rs1_data,
   input  logic [31:0]      rs2_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  alu_a,
   output logic [XLEN-1:0]  alu_b,
   output logic [3:0]       alu_op,
   output logic [4:0]       out_rd,
   output logic             out_wen,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_count
);

   localparam logic [6:0] c_opc_op    = 7'b0110011;
   localparam logic [6:0] c_opc_opimm = 7'b0010011;
   localparam logic [6:0] c_opc_lui   = 7'b0110111;
   localparam logic [6:0] c_opc_auipc = 7'b0010111;

   localparam logic [3:0] c_alu_nop  = 4'b0000;
   localparam logic [3:0] c_alu_add  = 4'b0001;
   localparam logic [3:0] c_alu_sub  = 4'b0010;
   localparam logic [3:0] c_alu_xor  = 4'b0011;
   localparam logic [3:0] c_alu_or   = 4'b0100;
   localparam logic [3:0] c_alu_and  = 4'b0101;
   localparam logic [3:0] c_alu_sll  = 4'b0110;
   localparam logic [3:0] c_alu_srl  = 4'b0111;
   localparam logic [3:0] c_alu_sra  = 4'b1001;
   localparam logic [3:0] c_alu_slt  = 4'b1010;
   localparam logic [3:0] c_alu_sltu = 4'b1011;

   localparam logic [6:0]       c_f7_zero = 7'b0000000;
   localparam logic [6:0]       c_f7_alt  = 7'b0100000;
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [6:0]      w_opc;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_shamt_r;
   logic [XLEN-1:0] w_shamt_i;
   logic [3:0]      w_op;
   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_b;
   logic            w_ill;
   logic            w_accept;
   logic            w_unused;

   logic             r_valid;
   logic [XLEN-1:0]  r_a;
   logic [XLEN-1:0]  r_b;
   logic [3:0]       r_op;
   logic [4:0]       r_rd;
   logic             r_wen;
   logic             r_ill;
   logic [CNT_W-1:0] r_cnt;

   assign w_opc     = in_instr[6:0];
   assign w_f3      = in_instr[14:12];
   assign w_f7      = in_instr[31:25];
   assign w_rd      = in_instr[11:7];
   assign w_imm_i   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign w_imm_u   = {in_instr[31:12], 12'b0};
   assign w_shamt_r = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
   assign w_shamt_i = {{(XLEN-5){1'b0}}, in_instr[24:20]};
   // rs1 field is resolved by the register file, not here
   assign w_unused  = &{1'b0, in_instr[19:15]};

   always_comb begin
      w_op  = c_alu_nop;
      w_a   = '0;
      w_b   = '0;
      w_ill = 1'b0;
      case (w_opc)
         c_opc_op: begin
            w_a = rs1_data;
            w_b = rs2_data;
            case (w_f3)
               3'b000:  w_op = w_f7[5] ? c_alu_sub : c_alu_add;
               3'b001:  w_op = c_alu_sll;
               3'b010:  w_op = c_alu_slt;
               3'b011:  w_op = c_alu_sltu;
               3'b100:  w_op = c_alu_xor;
               3'b101:  w_op = w_f7[5] ? c_alu_sra : c_alu_srl;
               3'b110:  w_op = c_alu_or;
               default: w_op = c_alu_and;
            endcase
            if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
               w_b = w_shamt_r;
            end
            w_ill = !(w_f7 == c_f7_zero ||
                      (w_f7 == c_f7_alt && (w_f3 == 3'b000 || w_f3 == 3'b101)));
         end
         c_opc_opimm: begin
            w_a = rs1_data;
            w_b = w_imm_i;
            case (w_f3)
               3'b000:  w_op = c_alu_add;
               3'b010:  w_op = c_alu_slt;
               3'b011:  w_op = c_alu_sltu;
               3'b100:  w_op = c_alu_xor;
               3'b110:  w_op = c_alu_or;
               3'b111:  w_op = c_alu_and;
               3'b001: begin
                  w_op  = c_alu_sll;
                  w_b   = w_shamt_i;
                  w_ill = (w_f7 != c_f7_zero);
               end
               default: begin
                  w_op  = w_f7[5] ? c_alu_sra : c_alu_srl;
                  w_b   = w_shamt_i;
                  w_ill = !(w_f7 == c_f7_zero || w_f7 == c_f7_alt);
               end
            endcase
         end
         c_opc_lui: begin
            w_op = c_alu_add;
            w_b  = w_imm_u;
         end
         c_opc_auipc: begin
            w_op = c_alu_add;
            w_a  = in_pc;
            w_b  = w_imm_u;
         end
         default: w_ill = 1'b1;
      endcase
      if (w_ill) begin
         w_op = c_alu_nop;
         w_a  = '0;
         w_b  = '0;
      end
   end

   assign in_ready = !flush && (!r_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Flush only clears valid; the data registers keep their last contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= c_alu_nop;
         r_rd    <= '0;
         r_wen   <= 1'b0;
         r_ill   <= 1'b0;
         r_cnt   <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_a     <= w_a;
         r_b     <= w_b;
         r_op    <= w_op;
         r_rd    <= w_rd;
         r_wen   <= !w_ill && (w_rd != 5'd0);
         r_ill   <= w_ill;
         if (w_ill && r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid     = r_valid;
   assign alu_a         = r_a;
   assign alu_b         = r_b;
   assign alu_op        = r_op;
   assign out_rd        = r_rd;
   assign out_wen       = r_wen;
   assign out_illegal   = r_ill;
   assign illegal_count = r_cnt;

endmodule
`default_nettype wire

// File: doc/alu_decode.md
# alu_decode

Execute-entry stage directly upstream of the ALU: decodes one RV32I integer instruction per cycle (OP, OP-IMM, LUI, AUIPC) into `alu_op`, `alu_a`, `alu_b` and writeback controls, and registers them. It is a single-entry pipeline register with a valid/ready handshake on both sides and a synchronous flush. The registered `alu_a`/`alu_b`/`alu_op` drive the ALU's combinational inputs directly, so ALU output is valid in the same cycle as `out_valid`.

## Interface
- `XLEN`, default 32: datapath width. Only 32 is supported.
- `CNT_W`, default 8: width of the illegal-instruction counter.

Ports, clock and reset first:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of `in_instr`.
- `rs1_data`, `rs2_data`  in  32  register-file read data for `in_instr`, valid in the same cycle.
- `flush`  in  1  kill the held entry; block acceptance this cycle.
- `out_valid`  out  1  registered outputs hold a valid op.
- `out_ready`  in  1  downstream consumes this cycle.
- `alu_a`, `alu_b`  out  32  ALU operands.
- `alu_op`  out  4  ALU opcode.
- `out_rd`  out  5  destination register.
- `out_wen`  out  1  writeback enable.
- `out_illegal`  out  1  instruction not decodable by this stage.
- `illegal_count`  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- ALU op codes: ADD=0001, SUB=0010, XOR=0011, OR=0100, AND=0101, SLL=0110, SRL=0111, SRA=1001, SLT=1010, SLTU=1011, NOP=0000 (ALU outputs 0). Code 1000 is never issued.
- OP (opcode 0110011): `alu_a`=rs1, `alu_b`=rs2.
  - funct3/funct7 map: 000/0000000 ADD, 000/0100000 SUB, 001/0000000 SLL, 010/0000000 SLT, 011/0000000 SLTU, 100/0000000 XOR, 101/0000000 SRL, 101/0100000 SRA, 110/0000000 OR, 111/0000000 AND.
  - Shifts use `alu_b`={27'b0, rs2[4:0]}, because the ALU shifts by the full `alu_b`.
- OP-IMM (opcode 0010011): `alu_a`=rs1, `alu_b`=sign-extended instr[31:20].
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
  - SLLI requires funct7=0000000. SRLI requires funct7=0000000. SRAI requires funct7=0100000.
  - For SLLI, SRLI and SRAI, `alu_b`={27'b0, instr[24:20]}.
- LUI (opcode 0110111): ADD, `alu_a`=0, `alu_b`={instr[31:12], 12'b0}.
- AUIPC (opcode 0010111): ADD, `alu_a`=in_pc, `alu_b`={instr[31:12], 12'b0}.
- Illegal instructions: any other opcode, or an unlisted funct7/funct3 combination.
  - Outputs: `alu_op`=NOP, `alu_a`=`alu_b`=0, `out_wen`=0, `out_illegal`=1.
  - The entry still passes through the handshake.
- `out_rd`=instr[11:7]. `out_wen`=1 for legal instructions with rd≠0, otherwise 0.
- Handshake:
  - `in_ready` = !out_valid | out_ready, and is forced to 0 while `flush`=1.
  - Accept = in_valid & in_ready. On accept, all outputs load and `out_valid`←1.
  - On out_ready without accept, `out_valid`←0 and the data registers hold.
- Flush has priority over everything: next cycle `out_valid`=0, and no accept happens in the flush cycle.
- `illegal_count` increments on each accepted illegal instruction and saturates at 2^CNT_W−1. Flush does not decrement it.

## Timing
- Reset: `out_valid`=0, `alu_a`=`alu_b`=0, `alu_op`=0000, `out_rd`=0, `out_wen`=0, `out_illegal`=0, `illegal_count`=0.
  - `in_ready`=1 during and after reset unless `flush`=1.
  - Reset mid-operation drops the held entry immediately (asynchronous).
- Latency is 1 cycle from accept to `out_valid`.
- Throughput is 1 per cycle with `out_ready` held high.
- `in_ready` is combinational from `out_valid`, `out_ready` and `flush`. Back-to-back accept while draining is required.
- While out_valid & !out_ready, all outputs are stable.
- `in_instr`, `in_pc` and rs data are sampled only on accept. Values while `in_valid`=0 have no effect.

## Test plan
- Reset, then ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, alu_op=0001, alu_a=5, alu_b=7, out_rd=3, out_wen=1.
- SRAI x4,x1,3 (funct7=0100000) with rs1=0x80000000 → alu_op=1001, alu_b=3.
  - SRA with rs2=0xFFFFFFE5 → alu_b=5.
- LUI x5,0xABCDE → alu_a=0, alu_b=0xABCDE000.
  - AUIPC with pc=0x100 and imm=1 → alu_a=0x100, alu_b=0x1000, alu_op=0001.
- Opcode 0000000, then ADD with funct7=0000001 → both out_illegal=1, alu_op=0000, out_wen=0, illegal_count=2.
  - Force the count to 255 and send another illegal → count stays 255.
- Backpressure: out_ready=0 with an entry held → in_ready=0 and outputs stable for 3 cycles.
  - Raise out_ready with in_valid=1 → the new entry loads the same edge.
- Flush with entry held and in_valid=1 → in_ready=0, next cycle out_valid=0, no accept.
  - Assert rst mid-stream → out_valid=0 immediately.
